// File: rtl/buffet_pkg.sv
// Shared buffet types: write-port preference and write-source encoding.
package buffet_pkg;

    typedef enum logic {
        PREF_FILL = 1'b0,
        PREF_UPD  = 1'b1
    } pref_t;

    localparam logic SRC_FILL = 1'b0;
    localparam logic SRC_UPD  = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/buffet_wport_arbiter.sv
// Weighted round-robin arbiter sharing one registered RAM write port between
// the buffet Fill and Update paths.
module buffet_wport_arbiter
    import buffet_pkg::*;
#(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int FILL_WEIGHT   = 4,
    parameter int UPDATE_WEIGHT = 1,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic [ADDR_WIDTH-1:0] fill_idx_i,
    input  logic [DATA_WIDTH-1:0] fill_data_i,
    input  logic                  fill_valid_i,
    output logic                  fill_ready_o,
    input  logic [ADDR_WIDTH-1:0] upd_idx_i,
    input  logic [DATA_WIDTH-1:0] upd_data_i,
    input  logic                  upd_valid_i,
    output logic                  upd_ready_o,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  wvalid_o,
    output logic                  wsrc_o,
    output logic [CNT_WIDTH-1:0]  conflict_cnt_o
);

    localparam int MAX_W      = max_int(FILL_WEIGHT, UPDATE_WEIGHT);
    localparam int BCNT_WIDTH = $clog2(MAX_W + 1);

    pref_t                 pref_q, pref_d;
    logic [BCNT_WIDTH-1:0] bcnt_q, bcnt_d, bcnt_inc;
    logic                  contest;
    logic                  gnt_fill, gnt_upd;

    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  wvalid_q;
    logic                  wsrc_q;

    // Burst accounting only advances on contested cycles, so an uncontested
    // stream from either side never disturbs the fairness window.
    always_comb begin
        pref_d   = pref_q;
        bcnt_d   = bcnt_q;
        gnt_fill = 1'b0;
        gnt_upd  = 1'b0;
        contest  = fill_valid_i & upd_valid_i;
        bcnt_inc = bcnt_q + 1'b1;
        if (contest) begin
            if (pref_q == PREF_FILL) begin
                gnt_fill = 1'b1;
                if (bcnt_inc == BCNT_WIDTH'(FILL_WEIGHT)) begin
                    pref_d = PREF_UPD;
                    bcnt_d = '0;
                end else begin
                    bcnt_d = bcnt_inc;
                end
            end else begin
                gnt_upd = 1'b1;
                if (bcnt_inc == BCNT_WIDTH'(UPDATE_WEIGHT)) begin
                    pref_d = PREF_FILL;
                    bcnt_d = '0;
                end else begin
                    bcnt_d = bcnt_inc;
                end
            end
        end else if (fill_valid_i) begin
            gnt_fill = 1'b1;
        end else if (upd_valid_i) begin
            gnt_upd = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            pref_q   <= PREF_FILL;
            bcnt_q   <= '0;
            wvalid_q <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            wsrc_q   <= SRC_FILL;
        end else begin
            pref_q   <= pref_d;
            bcnt_q   <= bcnt_d;
            wvalid_q <= gnt_fill | gnt_upd;
            if (gnt_fill) begin
                waddr_q <= fill_idx_i;
                wdata_q <= fill_data_i;
                wsrc_q  <= SRC_FILL;
            end else if (gnt_upd) begin
                waddr_q <= upd_idx_i;
                wdata_q <= upd_data_i;
                wsrc_q  <= SRC_UPD;
            end
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_conflict_cnt (
        .clk     (clk),
        .reset_i (reset_i),
        .inc_i   (contest),
        .count_o (conflict_cnt_o)
    );

    // Readies are combinational, so gate them to stay low through reset.
    assign fill_ready_o = gnt_fill & ~reset_i;
    assign upd_ready_o  = gnt_upd & ~reset_i;
    assign waddr_o      = waddr_q;
    assign wdata_o      = wdata_q;
    assign wvalid_o     = wvalid_q;
    assign wsrc_o       = wsrc_q;

endmodule

// File: tb/tb_buffet_wport_arbiter.sv
// Scoreboard bench for buffet_wport_arbiter: weights 4/1, 1/1 and a narrow counter.
module tb_buffet_wport_arbiter;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [7:0]  fill_idx_i, upd_idx_i;
    logic [31:0] fill_data_i, upd_data_i;
    logic        fill_valid_i, upd_valid_i;

    logic        fill_ready_a, upd_ready_a, wvalid_a, wsrc_a;
    logic [7:0]  waddr_a;
    logic [31:0] wdata_a;
    logic [15:0] conflict_a;

    logic        fill_ready_b, upd_ready_b, wvalid_b, wsrc_b;
    logic [7:0]  waddr_b;
    logic [31:0] wdata_b;
    logic [15:0] conflict_b;

    logic        fill_ready_c, upd_ready_c, wvalid_c, wsrc_c;
    logic [7:0]  waddr_c;
    logic [31:0] wdata_c;
    logic [3:0]  conflict_c;

    typedef struct packed {
        logic        valid;
        logic        src;
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t  exp_q[$];
    logic exp_b_q[$];
    wr_t  last_wr;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    buffet_wport_arbiter dut (
        .clk(clk), .reset_i(reset_i),
        .fill_idx_i(fill_idx_i), .fill_data_i(fill_data_i), .fill_valid_i(fill_valid_i),
        .fill_ready_o(fill_ready_a),
        .upd_idx_i(upd_idx_i), .upd_data_i(upd_data_i), .upd_valid_i(upd_valid_i),
        .upd_ready_o(upd_ready_a),
        .waddr_o(waddr_a), .wdata_o(wdata_a), .wvalid_o(wvalid_a), .wsrc_o(wsrc_a),
        .conflict_cnt_o(conflict_a)
    );

    buffet_wport_arbiter #(.FILL_WEIGHT(1), .UPDATE_WEIGHT(1)) dut_b (
        .clk(clk), .reset_i(reset_i),
        .fill_idx_i(fill_idx_i), .fill_data_i(fill_data_i), .fill_valid_i(fill_valid_i),
        .fill_ready_o(fill_ready_b),
        .upd_idx_i(upd_idx_i), .upd_data_i(upd_data_i), .upd_valid_i(upd_valid_i),
        .upd_ready_o(upd_ready_b),
        .waddr_o(waddr_b), .wdata_o(wdata_b), .wvalid_o(wvalid_b), .wsrc_o(wsrc_b),
        .conflict_cnt_o(conflict_b)
    );

    buffet_wport_arbiter #(.CNT_WIDTH(4)) dut_c (
        .clk(clk), .reset_i(reset_i),
        .fill_idx_i(fill_idx_i), .fill_data_i(fill_data_i), .fill_valid_i(fill_valid_i),
        .fill_ready_o(fill_ready_c),
        .upd_idx_i(upd_idx_i), .upd_data_i(upd_data_i), .upd_valid_i(upd_valid_i),
        .upd_ready_o(upd_ready_c),
        .waddr_o(waddr_c), .wdata_o(wdata_c), .wvalid_o(wvalid_c), .wsrc_o(wsrc_c),
        .conflict_cnt_o(conflict_c)
    );

    task automatic apply_reset();
        reset_i      = 1'b1;
        fill_valid_i = 1'b0;
        upd_valid_i  = 1'b0;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        exp_q.delete();
        exp_b_q.delete();
        last_wr = '0;
    endtask

    // One cycle on the main instance: check readies, push expected write,
    // then pop and compare the registered write after the edge.
    task automatic drive_cycle(input logic fv, input logic uv,
                               input logic [7:0] fi, input logic [31:0] fd,
                               input logic [7:0] ui, input logic [31:0] ud,
                               input logic exp_f, input logic exp_u, input string name);
        wr_t e;
        fill_valid_i = fv; upd_valid_i = uv;
        fill_idx_i = fi; fill_data_i = fd; upd_idx_i = ui; upd_data_i = ud;
        #1;
        tests_run++;
        if ({fill_ready_a, upd_ready_a} !== {exp_f, exp_u}) begin
            tests_failed++;
            $display("FAIL %s ready: got f=%b u=%b, want f=%b u=%b", name,
                     fill_ready_a, upd_ready_a, exp_f, exp_u);
        end
        if (exp_f)      e = '{valid: 1'b1, src: 1'b0, addr: fi, data: fd};
        else if (exp_u) e = '{valid: 1'b1, src: 1'b1, addr: ui, data: ud};
        else            e = '{valid: 1'b0, src: last_wr.src, addr: last_wr.addr, data: last_wr.data};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (e.valid) last_wr = e;
        tests_run++;
        if ({wvalid_a, wsrc_a, waddr_a, wdata_a} !== {e.valid, e.src, e.addr, e.data}) begin
            tests_failed++;
            $display("FAIL %s write: got v=%b s=%b a=%h d=%h, want v=%b s=%b a=%h d=%h", name,
                     wvalid_a, wsrc_a, waddr_a, wdata_a, e.valid, e.src, e.addr, e.data);
        end
        $display("[TB] %s fv=%b uv=%b -> v=%b s=%b a=%h d=%h cnt=%0d", name, fv, uv,
                 wvalid_a, wsrc_a, waddr_a, wdata_a, conflict_a);
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        fill_valid_i = 1'b1; upd_valid_i = 1'b1;
        fill_idx_i = 8'h11; fill_data_i = 32'h1111; upd_idx_i = 8'h22; upd_data_i = 32'h2222;
        @(posedge clk);
        #1;
        tests_run++;
        if ({wvalid_a, wsrc_a, waddr_a, wdata_a, conflict_a, fill_ready_a, upd_ready_a} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got v=%b s=%b a=%h d=%h cnt=%0d fr=%b ur=%b, want all zero",
                     wvalid_a, wsrc_a, waddr_a, wdata_a, conflict_a, fill_ready_a, upd_ready_a);
        end
        $display("[TB] reset v=%b cnt=%0d fr=%b ur=%b", wvalid_a, conflict_a, fill_ready_a, upd_ready_a);
        apply_reset();
    endtask

    task automatic test_fill_only();
        apply_reset();
        for (int i = 0; i < 10; i++)
            drive_cycle(1'b1, 1'b0, 8'(i), 32'hA0 + 32'(i), 8'h00, 32'h0, 1'b1, 1'b0, "fill_only");
        drive_cycle(1'b0, 1'b0, 8'h55, 32'h55, 8'h66, 32'h66, 1'b0, 1'b0, "fill_only_idle");
        tests_run++;
        if (conflict_a !== 16'd0) begin
            tests_failed++;
            $display("FAIL fill_only_cnt: got %0d, want 0", conflict_a);
        end
    endtask

    task automatic test_contest_4_1();
        logic exp_u [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        apply_reset();
        for (int i = 0; i < 10; i++)
            drive_cycle(1'b1, 1'b1, 8'h80 + 8'(i), 32'hB0 + 32'(i), 8'hC0 + 8'(i), 32'hD0 + 32'(i),
                        ~exp_u[i], exp_u[i], "contest_4_1");
        drive_cycle(1'b0, 1'b0, 8'h00, 32'h0, 8'h00, 32'h0, 1'b0, 1'b0, "contest_idle");
        tests_run++;
        if (conflict_a !== 16'd10) begin
            tests_failed++;
            $display("FAIL contest_cnt: got %0d, want 10", conflict_a);
        end
    endtask

    task automatic test_weights_1_1();
        logic want_u, got;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            want_u = (i % 2) == 1;
            fill_valid_i = 1'b1; upd_valid_i = 1'b1;
            fill_idx_i = 8'(i); upd_idx_i = 8'h40 + 8'(i);
            #1;
            tests_run++;
            if ({fill_ready_b, upd_ready_b} !== {~want_u, want_u}) begin
                tests_failed++;
                $display("FAIL w11_ready[%0d]: got f=%b u=%b, want f=%b u=%b", i,
                         fill_ready_b, upd_ready_b, ~want_u, want_u);
            end
            exp_b_q.push_back(want_u);
            @(posedge clk);
            #1;
            got = exp_b_q.pop_front();
            tests_run++;
            if ({wvalid_b, wsrc_b} !== {1'b1, got}) begin
                tests_failed++;
                $display("FAIL w11_src[%0d]: got v=%b s=%b, want v=1 s=%b", i, wvalid_b, wsrc_b, got);
            end
            $display("[TB] w11 cyc%0d -> v=%b s=%b a=%h", i, wvalid_b, wsrc_b, waddr_b);
        end
        fill_valid_i = 1'b0; upd_valid_i = 1'b0;
    endtask

    task automatic test_update_gap();
        apply_reset();
        for (int i = 0; i < 2; i++)
            drive_cycle(1'b1, 1'b1, 8'(i), 32'hE0 + 32'(i), 8'h30 + 8'(i), 32'hF0 + 32'(i), 1'b1, 1'b0, "gap_pre");
        for (int i = 0; i < 5; i++)
            drive_cycle(1'b0, 1'b1, 8'h00, 32'h0, 8'h50 + 8'(i), 32'h500 + 32'(i), 1'b0, 1'b1, "gap_upd");
        drive_cycle(1'b1, 1'b1, 8'h10, 32'h610, 8'h20, 32'h620, 1'b1, 1'b0, "gap_post");
        drive_cycle(1'b1, 1'b1, 8'h11, 32'h611, 8'h21, 32'h621, 1'b1, 1'b0, "gap_post");
        drive_cycle(1'b1, 1'b1, 8'h12, 32'h612, 8'h22, 32'h622, 1'b0, 1'b1, "gap_post");
    endtask

    task automatic test_reset_midburst();
        apply_reset();
        drive_cycle(1'b1, 1'b1, 8'h01, 32'h701, 8'h02, 32'h702, 1'b1, 1'b0, "mid_pre");
        drive_cycle(1'b1, 1'b1, 8'h03, 32'h703, 8'h04, 32'h704, 1'b1, 1'b0, "mid_pre");
        fill_valid_i = 1'b1; upd_valid_i = 1'b1;
        #1;
        reset_i = 1'b1;
        #1;
        tests_run++;
        if ({wvalid_a, fill_ready_a, upd_ready_a, conflict_a} !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset: got v=%b fr=%b ur=%b cnt=%0d, want all zero",
                     wvalid_a, fill_ready_a, upd_ready_a, conflict_a);
        end
        $display("[TB] mid_reset v=%b fr=%b ur=%b cnt=%0d", wvalid_a, fill_ready_a, upd_ready_a, conflict_a);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        exp_q.delete();
        last_wr = '0;
        for (int i = 0; i < 4; i++)
            drive_cycle(1'b1, 1'b1, 8'h90 + 8'(i), 32'h900 + 32'(i), 8'hA0, 32'hA00, 1'b1, 1'b0, "mid_post");
        drive_cycle(1'b1, 1'b1, 8'h94, 32'h904, 8'hA1, 32'hA01, 1'b0, 1'b1, "mid_post");
        tests_run++;
        if (conflict_a !== 16'd5) begin
            tests_failed++;
            $display("FAIL mid_cnt: got %0d, want 5", conflict_a);
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        fill_valid_i = 1'b1; upd_valid_i = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            @(posedge clk);
            #1;
            if (i == 14) begin
                tests_run++;
                if (conflict_c !== 4'd14) begin
                    tests_failed++;
                    $display("FAIL sat_14: got %0d, want 14", conflict_c);
                end
                $display("[TB] sat cyc14 cnt=%0d", conflict_c);
            end
        end
        fill_valid_i = 1'b0; upd_valid_i = 1'b0;
        tests_run++;
        if (conflict_c !== 4'hF) begin
            tests_failed++;
            $display("FAIL sat_final: got %h, want f", conflict_c);
        end
        tests_run++;
        if (conflict_a !== 16'd21) begin
            tests_failed++;
            $display("FAIL sat_wide: got %0d, want 21", conflict_a);
        end
        $display("[TB] sat cyc21 cnt4=%h cnt16=%0d", conflict_c, conflict_a);
    endtask

    initial begin
        reset_i = 1'b1;
        fill_valid_i = 1'b0; upd_valid_i = 1'b0;
        fill_idx_i = '0; fill_data_i = '0; upd_idx_i = '0; upd_data_i = '0;
        last_wr = '0;
        test_reset();
        test_fill_only();
        test_contest_4_1();
        test_weights_1_1();
        test_update_gap();
        test_reset_midburst();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1);
    end

endmodule

// File: doc/buffet_wport_arbiter.md
# buffet_wport_arbiter

Weighted round-robin arbiter that shares a single RAM write port between the buffet Fill path and the Update path. It is used when separate write ports are disabled. It sits between the buffet controller's fill/update outputs and the dpram write port 0. Arbitration is work-conserving, fairness is bounded and configurable, and the RAM sees one registered write per cycle.

## Interface
Parameters:
- ADDR_WIDTH, default 8: buffet index width.
- DATA_WIDTH, default 32: data width.
- FILL_WEIGHT, default 4: consecutive contested grants to Fill before yielding; must be ≥1.
- UPDATE_WEIGHT, default 1: consecutive contested grants to Update before yielding; must be ≥1.
- CNT_WIDTH, default 16: width of the saturating conflict counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- fill_idx_i  in  ADDR_WIDTH  Fill write address.
- fill_data_i  in  DATA_WIDTH  Fill write data.
- fill_valid_i  in  1  Fill request valid.
- fill_ready_o  out  1  Fill request accepted this cycle.
- upd_idx_i  in  ADDR_WIDTH  Update write address.
- upd_data_i  in  DATA_WIDTH  Update write data.
- upd_valid_i  in  1  Update request valid.
- upd_ready_o  out  1  Update request accepted this cycle.
- waddr_o  out  ADDR_WIDTH  RAM write address, registered.
- wdata_o  out  DATA_WIDTH  RAM write data, registered.
- wvalid_o  out  1  RAM write strobe, registered.
- wsrc_o  out  1  source of the current write: 0 = Fill, 1 = Update.
- conflict_cnt_o  out  CNT_WIDTH  saturating count of cycles in which both requests were valid.

## Operation
- State: `pref` ∈ {PREF_FILL, PREF_UPD} and a burst counter `bcnt`. `bcnt` is sized with $clog2(max(FILL_WEIGHT, UPDATE_WEIGHT)+1).
- Grant decision is combinational, made each cycle:
  - Only one request valid: that request is granted. `pref` and `bcnt` are unchanged.
  - Both requests valid: the preferred side is granted and `bcnt` increments.
  - Yield on contest: when the incremented `bcnt` equals the preferred side's weight, `pref` flips and `bcnt` clears.
  - Neither request valid: no grant; state is unchanged.
- Ready outputs:
  - fill_ready_o = grant to Fill.
  - upd_ready_o = grant to Update.
  - At most one ready is high per cycle.
  - A handshake is valid & ready in the same cycle.
- The output register captures the granted idx/data and the source, and sets wvalid_o = 1. When there is no grant, wvalid_o = 0 and waddr_o, wdata_o and wsrc_o hold their previous values.
- The RAM write port never back-pressures, so the output register never stalls.
- conflict_cnt_o increments on every cycle with fill_valid_i & upd_valid_i, and saturates at all-ones.
- No address-collision checking is done. Buffet semantics guarantee that Fill targets free slots and Update targets occupied slots.

## Timing
- Reset, asynchronous: while reset_i is high, all of the following are held and the readies are forced to 0:
  - wvalid_o = 0, waddr_o = 0, wdata_o = 0, wsrc_o = 0.
  - conflict_cnt_o = 0.
  - pref = PREF_FILL, bcnt = 0.
  - fill_ready_o = 0, upd_ready_o = 0.
- After reset deasserts, the first clock edge can accept a request.
- Latency: a request accepted at edge N produces wvalid_o = 1 with its idx/data during cycle N+1, i.e. 1 cycle.
- Throughput: one write per cycle, sustained.
- Contest bound: under continuous contention,
  - Update waits at most FILL_WEIGHT cycles;
  - Fill waits at most UPDATE_WEIGHT cycles.
- Reset mid-burst: in-flight register contents are discarded. A request that was handshaked in the cycle of reset assertion is lost; the producer's credit logic is also reset.

## Structure
- Shared package `buffet_pkg`:
  - enum `pref_t` {PREF_FILL, PREF_UPD};
  - constants SRC_FILL = 1'b0, SRC_UPD = 1'b1.
- Single module, plus one natural sub-module: `sat_counter` (parameterized width, inc, async reset), used for conflict_cnt_o.

## Test plan
- Fill only: 10 beats, idx 0..9, data 0xA0..0xA9, fill_valid continuous → fill_ready_o high every cycle; wvalid_o high for 10 cycles starting 1 cycle later; wsrc_o = 0; conflict_cnt_o = 0.
- Both valid continuously for 10 cycles, weights 4/1 → grant sequence F F F F U F F F F U; upd_ready_o high only in cycles 5 and 10; conflict_cnt_o = 10.
- Weights 1/1 with both valid for 6 cycles → F U F U F U; wsrc_o follows one cycle later.
- Update only for 5 cycles after 2 contested Fill grants (bcnt = 2), then contest resumes → 5 Update grants with bcnt unchanged, then F F U (the burst completes at 4).
- Assert reset_i during cycle 3 of a contested burst → wvalid_o and both readies drop to 0 immediately; after release, the first contested grant is Fill and conflict_cnt_o restarts from 0.
- Hold both valid for 2^CNT_WIDTH + 5 cycles with CNT_WIDTH = 4 → conflict_cnt_o saturates at 0xF.
